color_match_track: RTL and testbench

COLOR_MATCH_TRACK -- requirements
Module: color_match_track

---
 rtl/color_match_track_pkg.sv | 32 +++
 rtl/color_match_track_seq_divider.sv | 63 ++++++
 rtl/color_match_track.sv | 249 ++++++++++++++++++++++++
 tb/tb_color_match_track.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_match_track_pkg.sv
// Shared types and constants for the HSV colour-match tracker.
// Holds the tracker FSM encoding, the "no colour" reference and default tolerances.
package color_match_track_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_X   = 2'd1,
        ST_DIV_Y   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    localparam logic [23:0] HSV_CLEAR = 24'hFFFFFF;

    localparam int DEF_H_TOL   = 12;
    localparam int DEF_S_TOL   = 48;
    localparam int DEF_V_TOL   = 64;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_MIN_PIX = 64;

    function automatic logic [7:0] absDiff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Hue wraps around, so the shorter way round the 256-step circle wins.
    function automatic logic [7:0] hueDist(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = absDiff8(a, b);
        return (d > 8'd128) ? (8'd0 - d) : d;
    endfunction

endpackage

// File: rtl/color_match_track_seq_divider.sv
// Restoring sequential divider: 32-bit dividend, 21-bit divisor, one quotient bit per cycle.
// o_done pulses for one cycle 33 cycles after i_start; only the low 12 quotient bits leave.
module seq_divider (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [20:0] i_divisor,
    output logic [11:0] o_quotient,
    output logic        o_done
);

    logic [20:0] r_rem;
    logic [31:0] r_quot;
    logic [20:0] r_div;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    logic [21:0] w_remShift;
    logic        w_fits;
    logic [20:0] w_sub;

    always_comb begin
        w_remShift = {r_rem, r_quot[31]};
        w_fits     = (w_remShift >= {1'b0, r_div});
        w_sub      = w_remShift[20:0] - r_div;
    end

    // 32 shift/subtract steps, then one extra cycle to raise done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quot <= i_dividend;
                r_div  <= i_divisor;
                r_cnt  <= 6'd32;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_cnt != 6'd0) begin
                    r_cnt  <= r_cnt - 6'd1;
                    r_rem  <= w_fits ? w_sub : w_remShift[20:0];
                    r_quot <= {r_quot[30:0], w_fits};
                end else begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quotient = r_quot[11:0];
    assign o_done     = r_done;

endmodule

// File: rtl/color_match_track.sv
// HSV colour-match tracker: 2-stage per-pixel match, per-frame bounding box,
// pixel count and centroid published once per frame after two sequential divisions.
module color_match_track
    import color_match_track_pkg::*;
#(
    parameter int H_TOL   = DEF_H_TOL,
    parameter int S_TOL   = DEF_S_TOL,
    parameter int V_TOL   = DEF_V_TOL,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int MIN_PIX = DEF_MIN_PIX
) (
    input  logic        PClk,
    input  logic        rst_n,
    input  logic [11:0] VtcHCnt,
    input  logic [11:0] VtcVCnt,
    input  logic [23:0] HSV24,
    input  logic [23:0] HSV_detect,
    input  logic        sw_TrackEn,
    output logic        Binary_Out,
    output logic [11:0] Obj_XMin,
    output logic [11:0] Obj_XMax,
    output logic [11:0] Obj_YMin,
    output logic [11:0] Obj_YMax,
    output logic [11:0] Obj_CX,
    output logic [11:0] Obj_CY,
    output logic [20:0] Obj_Count,
    output logic        Obj_Valid,
    output logic        Frame_Done
);

    localparam logic [11:0] H_ACT_W   = 12'(H_ACT);
    localparam logic [11:0] V_ACT_W   = 12'(V_ACT);
    localparam logic [11:0] H_LAST    = 12'(H_ACT - 1);
    localparam logic [11:0] V_LAST    = 12'(V_ACT - 1);
    localparam logic [7:0]  H_TOL_W   = 8'(H_TOL);
    localparam logic [7:0]  S_TOL_W   = 8'(S_TOL);
    localparam logic [7:0]  V_TOL_W   = 8'(V_TOL);
    localparam logic [20:0] MIN_PIX_W = 21'(MIN_PIX);

    logic        r_s1Valid, r_s1Qual;
    logic [7:0]  r_s1DH, r_s1DS, r_s1DV;
    logic [11:0] r_s1HCnt, r_s1VCnt;
    logic        r_s2Valid, r_binOut;
    logic [11:0] r_s2HCnt, r_s2VCnt;

    logic [20:0] r_accCount;
    logic [31:0] r_accSumX, r_accSumY;
    logic [11:0] r_accXMin, r_accXMax, r_accYMin, r_accYMax;

    logic [20:0] r_snCount;
    logic [31:0] r_snSumY;
    logic [11:0] r_snXMin, r_snXMax, r_snYMin, r_snYMax;
    logic [11:0] r_cx, r_cy;

    logic [11:0] r_objXMin, r_objXMax, r_objYMin, r_objYMax, r_objCX, r_objCY;
    logic [20:0] r_objCount;
    logic        r_objValid, r_frameDone;

    state_t      r_state, w_nextState;

    logic        w_pixQual, w_frameEnd;
    logic [20:0] w_finCount;
    logic [31:0] w_finSumX, w_finSumY;
    logic [11:0] w_finXMin, w_finXMax, w_finYMin, w_finYMax;
    logic        w_divStart, w_divDone;
    logic [31:0] w_divDividend;
    logic [20:0] w_divisor;
    logic [11:0] w_quot;

    assign w_pixQual = (VtcHCnt < H_ACT_W) && (VtcVCnt < V_ACT_W) &&
                       sw_TrackEn && (HSV_detect != HSV_CLEAR);

    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Qual  <= 1'b0;
            r_s1DH    <= '0;
            r_s1DS    <= '0;
            r_s1DV    <= '0;
            r_s1HCnt  <= '0;
            r_s1VCnt  <= '0;
            r_s2Valid <= 1'b0;
            r_binOut  <= 1'b0;
            r_s2HCnt  <= '0;
            r_s2VCnt  <= '0;
        end else begin
            r_s1Valid <= 1'b1;
            r_s1Qual  <= w_pixQual;
            r_s1DH    <= hueDist(HSV24[23:16], HSV_detect[23:16]);
            r_s1DS    <= absDiff8(HSV24[15:8], HSV_detect[15:8]);
            r_s1DV    <= absDiff8(HSV24[7:0], HSV_detect[7:0]);
            r_s1HCnt  <= VtcHCnt;
            r_s1VCnt  <= VtcVCnt;
            r_s2Valid <= r_s1Valid;
            r_binOut  <= r_s1Valid && r_s1Qual && (r_s1DH <= H_TOL_W) &&
                         (r_s1DS <= S_TOL_W) && (r_s1DV <= V_TOL_W);
            r_s2HCnt  <= r_s1HCnt;
            r_s2VCnt  <= r_s1VCnt;
        end
    end

    // Accumulator values including the current stage-2 pixel; these are what a frame end snapshots.
    always_comb begin
        w_frameEnd = r_s2Valid && (r_s2HCnt == H_LAST) && (r_s2VCnt == V_LAST);
        w_finCount = r_accCount + 21'(r_binOut);
        w_finSumX  = r_accSumX + (r_binOut ? {20'd0, r_s2HCnt} : 32'd0);
        w_finSumY  = r_accSumY + (r_binOut ? {20'd0, r_s2VCnt} : 32'd0);
        w_finXMin  = (r_binOut && (r_s2HCnt < r_accXMin)) ? r_s2HCnt : r_accXMin;
        w_finXMax  = (r_binOut && (r_s2HCnt > r_accXMax)) ? r_s2HCnt : r_accXMax;
        w_finYMin  = (r_binOut && (r_s2VCnt < r_accYMin)) ? r_s2VCnt : r_accYMin;
        w_finYMax  = (r_binOut && (r_s2VCnt > r_accYMax)) ? r_s2VCnt : r_accYMax;
    end

    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n || w_frameEnd) begin
            r_accCount <= '0;
            r_accSumX  <= '0;
            r_accSumY  <= '0;
            r_accXMin  <= 12'hFFF;
            r_accXMax  <= '0;
            r_accYMin  <= 12'hFFF;
            r_accYMax  <= '0;
        end else begin
            r_accCount <= w_finCount;
            r_accSumX  <= w_finSumX;
            r_accSumY  <= w_finSumY;
            r_accXMin  <= w_finXMin;
            r_accXMax  <= w_finXMax;
            r_accYMin  <= w_finYMin;
            r_accYMax  <= w_finYMax;
        end
    end

    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // X division is fed straight from the frame-end values; Y division from the snapshot.
    always_comb begin
        w_nextState   = r_state;
        w_divStart    = 1'b0;
        w_divDividend = w_finSumX;
        w_divisor     = w_finCount;
        case (r_state)
            ST_IDLE: begin
                if (w_frameEnd) begin
                    if (w_finCount != 21'd0) begin
                        w_nextState = ST_DIV_X;
                        w_divStart  = 1'b1;
                    end else begin
                        w_nextState = ST_PUBLISH;
                    end
                end
            end
            ST_DIV_X: begin
                w_divDividend = r_snSumY;
                w_divisor     = r_snCount;
                if (w_divDone) begin
                    w_nextState = ST_DIV_Y;
                    w_divStart  = 1'b1;
                end
            end
            ST_DIV_Y: begin
                if (w_divDone) w_nextState = ST_PUBLISH;
            end
            ST_PUBLISH: w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    seq_divider u_divider (
        .i_clk      (PClk),
        .i_rst_n    (rst_n),
        .i_start    (w_divStart),
        .i_dividend (w_divDividend),
        .i_divisor  (w_divisor),
        .o_quotient (w_quot),
        .o_done     (w_divDone)
    );

    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n) begin
            r_snCount   <= '0;
            r_snSumY    <= '0;
            r_snXMin    <= '0;
            r_snXMax    <= '0;
            r_snYMin    <= '0;
            r_snYMax    <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_objXMin   <= '0;
            r_objXMax   <= '0;
            r_objYMin   <= '0;
            r_objYMax   <= '0;
            r_objCX     <= '0;
            r_objCY     <= '0;
            r_objCount  <= '0;
            r_objValid  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_frameEnd && (r_state == ST_IDLE)) begin
                r_snCount <= w_finCount;
                r_snSumY  <= w_finSumY;
                r_snXMin  <= w_finXMin;
                r_snXMax  <= w_finXMax;
                r_snYMin  <= w_finYMin;
                r_snYMax  <= w_finYMax;
            end
            if ((r_state == ST_DIV_X) && w_divDone) r_cx <= w_quot;
            if ((r_state == ST_DIV_Y) && w_divDone) r_cy <= w_quot;
            if (r_state == ST_PUBLISH) begin
                r_frameDone <= 1'b1;
                r_objCount  <= r_snCount;
                if (r_snCount == 21'd0) begin
                    r_objXMin  <= '0;
                    r_objXMax  <= '0;
                    r_objYMin  <= '0;
                    r_objYMax  <= '0;
                    r_objCX    <= '0;
                    r_objCY    <= '0;
                    r_objValid <= 1'b0;
                end else begin
                    r_objXMin  <= r_snXMin;
                    r_objXMax  <= r_snXMax;
                    r_objYMin  <= r_snYMin;
                    r_objYMax  <= r_snYMax;
                    r_objCX    <= r_cx;
                    r_objCY    <= r_cy;
                    r_objValid <= (r_snCount >= MIN_PIX_W);
                end
            end
        end
    end

    assign Binary_Out = r_binOut;
    assign Obj_XMin   = r_objXMin;
    assign Obj_XMax   = r_objXMax;
    assign Obj_YMin   = r_objYMin;
    assign Obj_YMax   = r_objYMax;
    assign Obj_CX     = r_objCX;
    assign Obj_CY     = r_objCY;
    assign Obj_Count  = r_objCount;
    assign Obj_Valid  = r_objValid;
    assign Frame_Done = r_frameDone;

endmodule

// File: tb/tb_color_match_track.sv
// Randomized self-checking bench for color_match_track on a reduced 32x24 active frame,
// using a pixel-level reference model and a queue of expected per-frame results.
module tb_color_match_track;

    localparam int H_ACT   = 32;
    localparam int V_ACT   = 24;
    localparam int H_TOT   = 40;
    localparam int V_TOT   = 28;
    localparam int H_TOL   = 12;
    localparam int S_TOL   = 48;
    localparam int V_TOL   = 64;
    localparam int MIN_PIX = 16;

    logic        PClk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] VtcHCnt = '0;
    logic [11:0] VtcVCnt = '0;
    logic [23:0] HSV24 = '0;
    logic [23:0] HSV_detect = 24'hFFFFFF;
    logic        sw_TrackEn = 1'b0;
    logic        Binary_Out;
    logic [11:0] Obj_XMin, Obj_XMax, Obj_YMin, Obj_YMax, Obj_CX, Obj_CY;
    logic [20:0] Obj_Count;
    logic        Obj_Valid, Frame_Done;

    typedef struct {
        int cnt;
        int xmin, xmax, ymin, ymax, cx, cy;
        int valid;
    } res_t;

    int   total = 0;
    int   bad = 0;
    res_t expQ[$];
    int   pendAge = 0;
    bit   exp1 = 1'b0;
    bit   exp2 = 1'b0;
    int   mCnt, mSumX, mSumY, mXMin, mXMax, mYMin, mYMax;

    always #5 PClk = ~PClk;

    color_match_track #(
        .H_TOL(H_TOL), .S_TOL(S_TOL), .V_TOL(V_TOL),
        .H_ACT(H_ACT), .V_ACT(V_ACT), .MIN_PIX(MIN_PIX)
    ) dut (
        .PClk       (PClk),
        .rst_n      (rst_n),
        .VtcHCnt    (VtcHCnt),
        .VtcVCnt    (VtcVCnt),
        .HSV24      (HSV24),
        .HSV_detect (HSV_detect),
        .sw_TrackEn (sw_TrackEn),
        .Binary_Out (Binary_Out),
        .Obj_XMin   (Obj_XMin),
        .Obj_XMax   (Obj_XMax),
        .Obj_YMin   (Obj_YMin),
        .Obj_YMax   (Obj_YMax),
        .Obj_CX     (Obj_CX),
        .Obj_CY     (Obj_CY),
        .Obj_Count  (Obj_Count),
        .Obj_Valid  (Obj_Valid),
        .Frame_Done (Frame_Done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit modelMatch(input int h, input int v, input logic [23:0] hsv,
                                      input logic [23:0] refHsv, input bit en);
        int dh, ds, dv;
        if (h >= H_ACT || v >= V_ACT || !en || refHsv == 24'hFFFFFF) return 1'b0;
        dh = int'(hsv[23:16]) - int'(refHsv[23:16]);
        if (dh < 0) dh = -dh;
        if (256 - dh < dh) dh = 256 - dh;
        ds = int'(hsv[15:8]) - int'(refHsv[15:8]);
        if (ds < 0) ds = -ds;
        dv = int'(hsv[7:0]) - int'(refHsv[7:0]);
        if (dv < 0) dv = -dv;
        return (dh <= H_TOL) && (ds <= S_TOL) && (dv <= V_TOL);
    endfunction

    task automatic modelClear();
        mCnt = 0; mSumX = 0; mSumY = 0;
        mXMin = 4095; mXMax = 0; mYMin = 4095; mYMax = 0;
    endtask

    task automatic checkFrameDone();
        res_t r;
        if (Frame_Done) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousFrameDone", 32'(Frame_Done), 32'd0);
            end else begin
                r = expQ.pop_front();
                pendAge = 0;
                checkOutput("objCount", 32'(Obj_Count), 32'(r.cnt));
                checkOutput("objXMin",  32'(Obj_XMin),  32'(r.xmin));
                checkOutput("objXMax",  32'(Obj_XMax),  32'(r.xmax));
                checkOutput("objYMin",  32'(Obj_YMin),  32'(r.ymin));
                checkOutput("objYMax",  32'(Obj_YMax),  32'(r.ymax));
                checkOutput("objCX",    32'(Obj_CX),    32'(r.cx));
                checkOutput("objCY",    32'(Obj_CY),    32'(r.cy));
                checkOutput("objValid", 32'(Obj_Valid), 32'(r.valid));
            end
        end else if (expQ.size() > 0) begin
            pendAge++;
            if (pendAge > 150) begin
                checkOutput("frameDoneTimeout", 32'(Frame_Done), 32'd1);
                void'(expQ.pop_front());
                pendAge = 0;
            end
        end
    endtask

    // One pixel per call: check outputs for older pixels, drive this one, update the model.
    task automatic applyStimulus(input int h, input int v, input logic [23:0] hsv,
                                 input logic [23:0] refHsv, input bit en);
        bit m;
        @(negedge PClk);
        checkOutput("binaryOut", 32'(Binary_Out), 32'(exp2));
        checkFrameDone();
        VtcHCnt    = 12'(h);
        VtcVCnt    = 12'(v);
        HSV24      = hsv;
        HSV_detect = refHsv;
        sw_TrackEn = en;
        m = modelMatch(h, v, hsv, refHsv, en);
        exp2 = exp1;
        exp1 = m;
        if (m) begin
            mCnt++; mSumX += h; mSumY += v;
            if (h < mXMin) mXMin = h;
            if (h > mXMax) mXMax = h;
            if (v < mYMin) mYMin = v;
            if (v > mYMax) mYMax = v;
        end
        if (h == H_ACT - 1 && v == V_ACT - 1) begin
            if (expQ.size() == 0) begin
                res_t r;
                if (mCnt == 0) begin
                    r = '{0, 0, 0, 0, 0, 0, 0, 0};
                end else begin
                    r.cnt = mCnt;
                    r.xmin = mXMin; r.xmax = mXMax; r.ymin = mYMin; r.ymax = mYMax;
                    r.cx = (mSumX / mCnt) % 4096;
                    r.cy = (mSumY / mCnt) % 4096;
                    r.valid = (mCnt >= MIN_PIX) ? 1 : 0;
                end
                expQ.push_back(r);
                pendAge = 0;
            end
            modelClear();
        end
    endtask

    function automatic logic [23:0] randRef();
        return {8'($urandom_range(0, 255)), 8'($urandom_range(48, 207)), 8'($urandom_range(64, 191))};
    endfunction

    function automatic logic [23:0] pixelFor(input int mode, input int h, input int v,
                                             input logic [23:0] refHsv);
        bit active;
        active = (h < H_ACT) && (v < V_ACT);
        case (mode)
            0: return 24'h406080;
            1: return {(h < 16) ? 8'd4 : 8'd8, 8'd100, 8'd100};
            2: return (!active || (h >= 10 && h <= 17 && v >= 5 && v <= 12)) ? refHsv
                      : {refHsv[23:16] + 8'd128, refHsv[15:0]};
            3: return (!active || (h == H_ACT - 1 && v == V_ACT - 1)) ? refHsv
                      : {refHsv[23:16] + 8'd60, refHsv[15:0]};
            default: return {refHsv[23:16] + 8'($urandom_range(0, 40)) - 8'd20,
                             refHsv[15:8] + 8'($urandom_range(0, 120)) - 8'd60,
                             refHsv[7:0] + 8'($urandom_range(0, 160)) - 8'd80};
        endcase
    endfunction

    task automatic driveFrame(input int mode, input int lastLine);
        logic [23:0] refHsv;
        bit en;
        case (mode)
            0:       refHsv = 24'hFFFFFF;
            1:       refHsv = {8'd250, 8'd100, 8'd100};
            2, 3:    refHsv = {8'd100, 8'd150, 8'd150};
            default: refHsv = randRef();
        endcase
        for (int v = 0; v <= lastLine; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                if (mode == 4 && v == V_ACT / 2 && h == 0)
                    refHsv = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : randRef();
                en = (mode == 4) ? ($urandom_range(0, 15) != 0) : 1'b1;
                applyStimulus(h, v, pixelFor(mode, h, v, refHsv), refHsv, en);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(H_TOT - 1, V_TOT - 1, 24'h000000, 24'hFFFFFF, 1'b0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rstBinaryOut", 32'(Binary_Out), 32'd0);
        checkOutput("rstObjCount",  32'(Obj_Count),  32'd0);
        checkOutput("rstObjXMax",   32'(Obj_XMax),   32'd0);
        checkOutput("rstObjCX",     32'(Obj_CX),     32'd0);
        checkOutput("rstObjValid",  32'(Obj_Valid),  32'd0);
        checkOutput("rstFrameDone", 32'(Frame_Done), 32'd0);
        exp1 = 1'b0;
        exp2 = 1'b0;
        expQ.delete();
        pendAge = 0;
        modelClear();
        idleCycles(3);
        rst_n = 1'b1;
    endtask

    initial begin
        modelClear();
        #1 rst_n = 1'b0;
        #2;
        checkOutput("initObjCount",  32'(Obj_Count),  32'd0);
        checkOutput("initObjYMin",   32'(Obj_YMin),   32'd0);
        checkOutput("initObjValid",  32'(Obj_Valid),  32'd0);
        checkOutput("initFrameDone", 32'(Frame_Done), 32'd0);
        checkOutput("initBinaryOut", 32'(Binary_Out), 32'd0);
        idleCycles(3);
        rst_n = 1'b1;

        $display("[TB] no reference colour");
        driveFrame(0, V_TOT - 1);
        $display("[TB] hue wrap-around");
        driveFrame(1, V_TOT - 1);
        $display("[TB] square object");
        driveFrame(2, V_TOT - 1);
        $display("[TB] corner pixel");
        driveFrame(3, V_TOT - 1);

        $display("[TB] frame end while dividing");
        driveFrame(2, V_ACT - 1);
        for (int h = 0; h < 4; h++)
            applyStimulus(h, 0, {8'd100, 8'd150, 8'd150}, {8'd100, 8'd150, 8'd150}, 1'b1);
        applyStimulus(H_ACT - 1, V_ACT - 1, {8'd100, 8'd150, 8'd150}, {8'd100, 8'd150, 8'd150}, 1'b1);
        idleCycles(100);
        driveFrame(3, V_TOT - 1);

        $display("[TB] reset during division");
        driveFrame(2, V_ACT - 1);
        idleCycles(5);
        doReset();
        driveFrame(2, V_TOT - 1);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) driveFrame(4, V_TOT - 1);

        idleCycles(200);
        checkOutput("pendingAtEnd", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
